ssd_reader: RTL and testbench

SSD_READER -- requirements
Module: ssd_reader

---
 rtl/ssd_pkg.sv | 57 +++++
 rtl/ssd_digit_track.sv | 93 +++++++++
 rtl/ssd_reader.sv | 60 ++++++
 tb/tb_ssd_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared seven-segment constants and the pattern-to-code decoder.
// Latency: combinational helper only, no state.
// Backpressure: none; pure constants and a function.
// Optional hex letters A-F are enabled by defining SSD_READER_HEX_EN.
package ssd_pkg;

    localparam int NUM_DIGITS = 4;

    // Segment order is {A,B,C,D,E,F,G}, A in the MSB.
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    localparam logic [6:0] SEG_TBL [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };

`ifdef SSD_READER_HEX_EN
    localparam int NUM_CODES = 16;
`else
    localparam int NUM_CODES = 10;
`endif

    typedef struct packed {
        logic       ok;
        logic [3:0] code;
    } dec_t;

    // Table index is the code; only the first NUM_CODES entries are legal.
    function automatic dec_t ssd_decode(input logic [6:0] pat);
        dec_t d;
        d.ok   = 1'b0;
        d.code = 4'd0;
        for (int k = 0; k < NUM_CODES; k++) begin
            if (pat == SEG_TBL[k]) begin
                d.ok   = 1'b1;
                d.code = 4'(k);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/ssd_digit_track.sv
// Per-digit debounce/commit tracker: candidate, match run, staleness age, outputs.
// Latency: commit registered on the edge the run reaches STABLE_CNT.
// Backpressure: none; samples are consumed every cycle they are offered.
module ssd_digit_track
    import ssd_pkg::*;
#(
    parameter int STABLE_CNT = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_smp_vld,
    input  logic [6:0] i_smp_dat,
    output logic [3:0] o_code,
    output logic       o_valid,
    output logic       o_err,
    output logic       o_upd
);

    localparam logic [3:0]  LP_STB    = 4'(STABLE_CNT);
    localparam logic [3:0]  LP_STB_M1 = 4'(STABLE_CNT - 1);
    localparam logic [15:0] LP_TO     = 16'(TIMEOUT);
    localparam logic [15:0] LP_TO_M1  = 16'(TIMEOUT - 1);

    logic [6:0]  r_cand;
    logic [3:0]  r_cnt;
    logic [15:0] r_age;
    logic [3:0]  r_code;
    logic        r_valid;
    logic        r_err;
    logic        r_upd;

    logic w_match;
    logic w_commit;
    logic w_blank;
    dec_t w_dec;

    assign w_match  = (i_smp_dat == r_cand);
    // A new candidate commits at once only when a single sample suffices.
    assign w_commit = i_smp_vld && (w_match ? (r_cnt == LP_STB_M1) : (STABLE_CNT == 1));
    assign w_blank  = (i_smp_dat == 7'd0);
    assign w_dec    = ssd_decode(i_smp_dat);

    // Run tracking, staleness ageing and committed output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand  <= 7'd0;
            r_cnt   <= 4'd0;
            r_age   <= 16'd0;
            r_code  <= 4'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_upd   <= 1'b0;
        end else begin
            r_upd <= w_commit;
            if (i_smp_vld) begin
                r_age <= 16'd0;
                if (w_match) begin
                    if (r_cnt < LP_STB) r_cnt <= r_cnt + 4'd1;
                end else begin
                    r_cand <= i_smp_dat;
                    r_cnt  <= 4'd1;
                end
            end else if (r_age < LP_TO) begin
                // Age saturates at TIMEOUT so the stale event fires once.
                r_age <= r_age + 16'd1;
                if (r_age == LP_TO_M1) begin
                    r_valid <= 1'b0;
                    r_cnt   <= 4'd0;
                end
            end
            if (w_commit) begin
                if (w_blank) begin
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                end else if (w_dec.ok) begin
                    r_code  <= w_dec.code;
                    r_valid <= 1'b1;
                    r_err   <= 1'b0;
                end else begin
                    r_valid <= 1'b0;
                    r_err   <= 1'b1;
                end
            end
        end
    end

    assign o_code  = r_code;
    assign o_valid = r_valid;
    assign o_err   = r_err;
    assign o_upd   = r_upd;

endmodule

// File: rtl/ssd_reader.sv
// Recovers digit codes from a multiplexed 4-digit seven-segment display bus.
// Latency: one input register stage, then STABLE_CNT matching samples to commit.
// Backpressure: none; display is sampled every cycle. Hex letters via SSD_READER_HEX_EN.
module ssd_reader
    import ssd_pkg::*;
#(
    parameter int STABLE_CNT = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        A,
    input  logic        B,
    input  logic        C,
    input  logic        D,
    input  logic        E,
    input  logic        F,
    input  logic        G,
    input  logic [3:0]  dig_en,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  err,
    output logic [3:0]  upd
);

    logic [6:0] r_seg;
    logic [3:0] r_en;
    logic       w_qual;

    // Input stage: pins are asynchronous to our view of the display scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= 7'd0;
            r_en  <= 4'd0;
        end else begin
            r_seg <= {A, B, C, D, E, F, G};
            r_en  <= dig_en;
        end
    end

    // Ghosting during digit transitions shows up as zero- or multi-hot enables.
    assign w_qual = (r_en != 4'd0) && ((r_en & (r_en - 4'd1)) == 4'd0);

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
        ssd_digit_track #(
            .STABLE_CNT (STABLE_CNT),
            .TIMEOUT    (TIMEOUT)
        ) u_trk (
            .clk       (clk),
            .rst       (rst),
            .i_smp_vld (w_qual & r_en[gi]),
            .i_smp_dat (r_seg),
            .o_code    (digits[4*gi +: 4]),
            .o_valid   (digit_valid[gi]),
            .o_err     (err[gi]),
            .o_upd     (upd[gi])
        );
    end

endmodule

// File: tb/tb_ssd_reader.sv
// Self-checking bench for ssd_reader with a commit scoreboard.
// Latency: checks commits STABLE_CNT+1 edges after a steady pattern appears.
// Backpressure: not applicable; expectations follow SSD_READER_HEX_EN.
module tb_ssd_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        A, B, C, D, E, F, G;
    logic [3:0]  dig_en;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  err;
    logic [3:0]  upd;

    int total = 0;
    int bad   = 0;
    int n_upd = 0;
    int base;

    typedef struct {
        int         dig;
        logic [3:0] code;
        logic       vld;
        logic       er;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    ssd_reader #(.STABLE_CNT(3), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
        .dig_en(dig_en), .digits(digits), .digit_valid(digit_valid),
        .err(err), .upd(upd)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] p, input logic [3:0] e);
        {A, B, C, D, E, F, G} = p;
        dig_en = e;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input int d, input logic [3:0] c, input logic v, input logic e);
        exp_t x;
        x.dig = d; x.code = c; x.vld = v; x.er = e;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(7'd0, 4'd0);
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard: every upd pulse must match the next expected commit.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (upd[i]) begin
                    n_upd++;
                    if (sb.size() == 0) begin
                        chk("sb_extra_upd", 32'(i), 32'hFF);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("sb_dig",  32'(i), 32'(mon_e.dig));
                        chk("sb_code", 32'(digits[4*i +: 4]), 32'(mon_e.code));
                        chk("sb_vld",  32'(digit_valid[i]), 32'(mon_e.vld));
                        chk("sb_err",  32'(err[i]), 32'(mon_e.er));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] pats [4];
        logic [3:0] codes [4];
        logic [6:0] seq [6];
        pats  = '{7'b0110000, 7'b1101101, 7'b0110011, 7'b1111111};
        codes = '{4'd1, 4'd2, 4'd4, 4'd8};
        seq   = '{7'b1111110, 7'b1111110, 7'b0110000, 7'b1111110, 7'b1111110, 7'b1111110};

        drive(7'b1010101, 4'b0001);
        @(negedge clk);
        do_reset();
        chk("rst_digits", 32'(digits), 0);
        chk("rst_valid",  32'(digit_valid), 0);
        chk("rst_err",    32'(err), 0);
        chk("rst_upd",    32'(upd), 0);

        // Steady "3" on digit 0 commits on edge 4.
        do_reset();
        drive(7'b1111001, 4'b0001);
        push(0, 4'd3, 1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("t1_upd_edge", 32'(upd[0]), 32'(k == 4));
        end
        chk("t1_digit", 32'(digits[3:0]), 3);
        chk("t1_valid", 32'(digit_valid), 32'h1);

        // Rotating scan, one digit per cycle, three laps.
        do_reset();
        base = n_upd;
        for (int lap = 0; lap < 3; lap++) begin
            for (int d = 0; d < 4; d++) begin
                drive(pats[d], 4'(1 << d));
                if (lap == 2) push(d, codes[d], 1'b1, 1'b0);
                tick();
            end
        end
        drive(7'd0, 4'd0);
        tick();
        tick();
        chk("t2_digits", 32'(digits), 32'h8421);
        chk("t2_valid",  32'(digit_valid), 32'hF);
        chk("t2_nupd",   32'(n_upd - base), 4);

        // Interrupted run: the lone "1" must not commit.
        do_reset();
        base = n_upd;
        push(0, 4'd0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            drive(seq[k], 4'b0001);
            tick();
        end
        drive(7'd0, 4'd0);
        tick();
        tick();
        tick();
        chk("t3_nupd",  32'(n_upd - base), 1);
        chk("t3_valid", 32'(digit_valid[0]), 1);
        chk("t3_err",   32'(err[0]), 0);

        // Multi-hot and zero-hot enables must be ignored.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(7'($urandom), (k % 2 == 1) ? 4'b0011 : 4'b0000);
            tick();
            chk("t4_no_upd", 32'(upd), 0);
        end
        chk("t4_digits", 32'(digits), 0);
        chk("t4_valid",  32'(digit_valid), 0);
        chk("t4_err",    32'(err), 0);
        drive(7'b1110000, 4'b0001);
        push(0, 4'd7, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t4_commit_edge", 32'(upd[0]), 32'(k == 4));
        end

        // Letter "A", then blank pattern.
        do_reset();
        drive(7'b1110111, 4'b0001);
`ifdef SSD_READER_HEX_EN
        push(0, 4'd10, 1'b1, 1'b0);
`else
        push(0, 4'd0, 1'b0, 1'b1);
`endif
        for (int k = 0; k < 5; k++) tick();
`ifdef SSD_READER_HEX_EN
        chk("t5_err",   32'(err[0]), 0);
        chk("t5_valid", 32'(digit_valid[0]), 1);
        chk("t5_digit", 32'(digits[3:0]), 32'hA);
`else
        chk("t5_err",   32'(err[0]), 1);
        chk("t5_valid", 32'(digit_valid[0]), 0);
        chk("t5_digit", 32'(digits[3:0]), 0);
`endif
        drive(7'b0000000, 4'b0001);
`ifdef SSD_READER_HEX_EN
        push(0, 4'd10, 1'b0, 1'b0);
`else
        push(0, 4'd0, 1'b0, 1'b0);
`endif
        for (int k = 0; k < 5; k++) tick();
        chk("t5_blank_valid", 32'(digit_valid[0]), 0);
        chk("t5_blank_err",   32'(err[0]), 0);

        // Staleness on digit 2, then reset in the middle of a run.
        do_reset();
        drive(7'b1111011, 4'b0100);
        push(2, 4'd9, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        chk("t6_commit", 32'(upd[2]), 1);
        drive(7'b1111011, 4'b0000);
        // One more edge still consumes the registered digit-2 sample.
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("t6_still_valid", 32'(digit_valid[2]), 1);
        end
        tick();
        chk("t6_stale_valid", 32'(digit_valid[2]), 0);
        chk("t6_stale_digit", 32'(digits[11:8]), 9);
        chk("t6_stale_err",   32'(err[2]), 0);

        drive(7'b1111001, 4'b0001);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("t6_rst_digits", 32'(digits), 0);
        chk("t6_rst_valid",  32'(digit_valid), 0);
        chk("t6_rst_err",    32'(err), 0);
        chk("t6_rst_upd",    32'(upd), 0);
        rst = 1'b0;
        push(0, 4'd3, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t6_rerun_edge", 32'(upd[0]), 32'(k == 4));
        end

        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
